bpug_act_pack: RTL and testbench

- Downstream stage of the BPU group.
- Consumes the eight signed 7-bit popcount sums the BPU group produces each cycle.
- Per channel: thresholds the sum (folded batch-norm plus sign) into a binary activation, then optionally max-pools over consecutive samples (logical OR).
- Packs the eight channel bits into one byte and buffers it in a small FIFO for the output writer, with valid/ready flow control on both sides.

---
 rtl/bpug_act_pack_if.sv | 24 ++
 rtl/bpug_act_pack.sv | 120 ++++++++++++
 tb/tb_bpug_act_pack.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bpug_act_pack_if.sv
// Handshake and control bundle between the BPU group and the activation packer.
interface bpug_act_pack_if;
  logic [55:0] acc_in;
  logic        acc_valid;
  logic        acc_ready;
  logic        pool_en;
  logic        flush;
  logic        thr_load;
  logic [6:0]  thr_in;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_count;

  modport master (
    output acc_in, acc_valid, pool_en, flush, thr_load, thr_in, out_ready,
    input  acc_ready, out_data, out_valid, out_count
  );

  modport slave (
    input  acc_in, acc_valid, pool_en, flush, thr_load, thr_in, out_ready,
    output acc_ready, out_data, out_valid, out_count
  );
endinterface

// File: rtl/bpug_act_pack.sv
// Activation stage: per-channel signed threshold, optional OR max-pool over
// POOL_N samples, byte packing and a small output FIFO.

// One channel's binarisation: full signed compare of sum against threshold.
module bpug_act_lane #(
  parameter int VEC_W = 7
) (
  input  logic [VEC_W-1:0] acc,
  input  logic [VEC_W-1:0] thr,
  output logic             act
);
  assign act = ($signed(acc) >= $signed(thr));
endmodule

module bpug_act_pack #(
  parameter int POOL_N     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  bpug_act_pack_if.slave   bus
);
  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 7;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int CW        = (POOL_N > 1) ? $clog2(POOL_N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(POOL_N - 1);
  localparam logic [AW:0]   DEPTH_C  = FIFO_DEPTH[AW:0];

  logic [NUM_LANES-1:0][VEC_W-1:0] thr, acc;
  logic [NUM_LANES-1:0]            act, pool_reg, w, push_data;
  logic [CW-1:0]                   cnt;
  logic [FIFO_DEPTH-1:0][7:0]      mem;
  logic [AW-1:0]                   wr_ptr, rd_ptr;
  logic [AW:0]                     count;
  logic full, empty, samp, fl, push, pop, clr, inc;

  assign acc   = bus.acc_in;
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  // Ready is a pure function of registered occupancy, never of out_ready.
  assign bus.acc_ready = !full;
  assign samp  = bus.acc_valid & !full;
  assign fl    = bus.flush & !full;
  assign pop   = !empty & bus.out_ready;
  assign w     = pool_reg | act;

  for (genvar c = 0; c < NUM_LANES; c++) begin : g_lane
    bpug_act_lane #(.VEC_W(VEC_W)) u_lane (
      .acc (acc[c]),
      .thr (thr[c]),
      .act (act[c])
    );
  end

  // Threshold shift chain; a load in the same cycle as a sample lands after the compare.
  always_ff @(posedge clk) begin
    if (rst)               thr <= '0;
    else if (bus.thr_load) thr <= {thr[NUM_LANES-2:0], bus.thr_in};
  end

  // Push / window-advance decision; at most one push per cycle.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    clr       = 1'b0;
    inc       = 1'b0;
    if (samp) begin
      if (fl || !bus.pool_en || cnt == CNT_LAST) begin
        // w equals act when no window is open, so one path covers pool_en=0 too.
        push      = 1'b1;
        push_data = w;
        clr       = 1'b1;
      end else begin
        inc = 1'b1;
      end
    end else if (fl && cnt != '0) begin
      push      = 1'b1;
      push_data = pool_reg;
      clr       = 1'b1;
    end
  end

  // Pool window state: running OR and sample count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt      <= '0;
      pool_reg <= '0;
    end else if (inc) begin
      cnt      <= cnt + CW'(1);
      pool_reg <= w;
    end
  end

  // FIFO storage; contents need no reset since out_data is masked when empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? 8'h00 : mem[rd_ptr];
  assign bus.out_count = 5'(count);
endmodule

// File: tb/tb_bpug_act_pack.sv
// Randomised and directed bench for bpug_act_pack against a queue-based model.
module tb_bpug_act_pack;
  localparam int POOL_N     = 4;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bpug_act_pack_if bus();

  bpug_act_pack #(.POOL_N(POOL_N), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: thr_hist[k] is the value loaded k loads ago (= thr[k]);
  // win holds the activations of the open pool window; exp_q is the FIFO.
  logic [6:0] thr_hist[$];
  logic [7:0] win[$];
  logic [7:0] exp_q[$];

  function automatic logic [7:0] model_act(logic [55:0] a_in);
    logic [7:0] r;
    logic [6:0] av, tv;
    int a, t;
    r = '0;
    for (int c = 0; c < 8; c++) begin
      av = a_in[7*c +: 7];
      tv = (c < thr_hist.size()) ? thr_hist[c] : 7'd0;
      a = int'($signed(av));
      t = int'($signed(tv));
      r[c] = (a >= t);
    end
    return r;
  endfunction

  // Advance model by one clock using the inputs currently driven, then clock.
  task automatic tick();
    logic ready, samp, fl, emit;
    logic [7:0] a, e;
    if (rst) begin
      thr_hist.delete(); win.delete(); exp_q.delete();
    end else begin
      ready = (exp_q.size() < FIFO_DEPTH);
      samp  = bus.acc_valid && ready;
      fl    = bus.flush && ready;
      a     = model_act(bus.acc_in);
      emit  = 1'b0;
      e     = '0;
      if (samp) begin
        win.push_back(a);
        if (fl || !bus.pool_en || win.size() == POOL_N) emit = 1'b1;
      end else if (fl && win.size() != 0) emit = 1'b1;
      if (emit) begin
        foreach (win[i]) e |= win[i];
        win.delete();
      end
      if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
      if (emit) exp_q.push_back(e);
      if (bus.thr_load) begin
        thr_hist.push_front(bus.thr_in);
        if (thr_hist.size() > 8) void'(thr_hist.pop_back());
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.acc_in = '0; bus.acc_valid = 0; bus.pool_en = 0; bus.flush = 0;
    bus.thr_load = 0; bus.thr_in = '0; bus.out_ready = 0;
  endtask

  task automatic load_thr(input logic [6:0] v);
    bus.thr_load = 1; bus.thr_in = v; tick(); bus.thr_load = 0;
  endtask

  task automatic send(input logic [55:0] v);
    bus.acc_in = v; bus.acc_valid = 1; tick(); bus.acc_valid = 0;
  endtask

  task automatic drain();
    bus.out_ready = 1; bus.acc_valid = 0; bus.flush = 0;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    bus.out_ready = 0;
  endtask

  function automatic logic [55:0] acc_for(input logic [7:0] pat);
    logic [55:0] r;
    for (int c = 0; c < 8; c++) r[7*c +: 7] = pat[c] ? 7'h00 : 7'h7F;
    return r;
  endfunction

  task automatic test_reset();
    idle(); rst = 1; tick(); tick(); rst = 0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", bus.out_data); end
    checks++; if (bus.out_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.out_count); end
    checks++; if (bus.acc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.acc_ready); end
  endtask

  task automatic test_thresholds();
    for (int i = 0; i < 8; i++) load_thr(7'(i));
    // thr[c] = 7-c, so all-4 sums fire channels 3..7.
    send({8{7'd4}});
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL thr_valid got %b exp 1", bus.out_valid); end
    checks++; if (bus.out_count !== 5'd1) begin errors++; $display("FAIL thr_count got %0d exp 1", bus.out_count); end
    checks++; if (bus.out_data !== 8'hF8 || bus.out_data !== exp_q[0]) begin errors++; $display("FAIL thr_data got %h exp f8", bus.out_data); end
    drain();
  endtask

  task automatic test_signed();
    for (int i = 0; i < 8; i++) load_thr(7'h7F);
    send({4{7'h7E, 7'h7F}});
    checks++; if (bus.out_data !== 8'h55) begin errors++; $display("FAIL signed_m1 got %h exp 55", bus.out_data); end
    drain();
    for (int i = 0; i < 8; i++) load_thr(7'h00);
    send({8{7'h40}});
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h00) begin errors++; $display("FAIL signed_m64_vs0 got v=%b d=%h exp v=1 d=00", bus.out_valid, bus.out_data); end
    drain();
    for (int i = 0; i < 8; i++) load_thr(7'h40);
    send({8{7'h40}});
    checks++; if (bus.out_data !== 8'hFF) begin errors++; $display("FAIL signed_m64_eq got %h exp ff", bus.out_data); end
    drain();
  endtask

  task automatic test_pooling();
    logic [7:0] pats[4];
    pats = '{8'h01, 8'h02, 8'h00, 8'h80};
    for (int i = 0; i < 8; i++) load_thr(7'h00);
    bus.pool_en = 1;
    for (int i = 0; i < 4; i++) begin
      send(acc_for(pats[i]));
      if (i < 3) begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL pool_early_push%0d got %b exp 0", i, bus.out_valid); end
      end else begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h83) begin errors++; $display("FAIL pool_or got v=%b d=%h exp v=1 d=83", bus.out_valid, bus.out_data); end
      end
    end
    drain();
    for (int i = 0; i < 3; i++) send(acc_for(8'h10));
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL pool_partial got %b exp 0", bus.out_valid); end
    bus.flush = 1; tick(); bus.flush = 0;
    checks++; if (bus.out_data !== 8'h10 || bus.out_count !== 5'd1) begin errors++; $display("FAIL pool_flush got d=%h n=%0d exp d=10 n=1", bus.out_data, bus.out_count); end
    drain();
    bus.flush = 1; tick(); bus.flush = 0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL pool_flush_empty got %b exp 0", bus.out_valid); end
    bus.pool_en = 0;
  endtask

  task automatic test_thr_coincide();
    for (int i = 0; i < 8; i++) load_thr(7'h00);
    bus.acc_in = {8{7'd5}}; bus.acc_valid = 1; bus.thr_load = 1; bus.thr_in = 7'h3F;
    tick();
    bus.acc_valid = 0; bus.thr_load = 0;
    checks++; if (bus.out_data !== 8'hFF) begin errors++; $display("FAIL thr_same_cycle got %h exp ff", bus.out_data); end
    drain();
    send({8{7'd5}});
    checks++; if (bus.out_data !== 8'hFE) begin errors++; $display("FAIL thr_after_load got %h exp fe", bus.out_data); end
    drain();
  endtask

  task automatic test_backpressure();
    logic [55:0] s[6];
    int i, cyc, pops;
    logic acc_ok;
    for (int k = 0; k < 8; k++) load_thr(7'($urandom()));
    for (int k = 0; k < 6; k++) s[k] = 56'({$urandom(), $urandom()});
    bus.pool_en = 0; bus.out_ready = 0;
    i = 0; cyc = 0; pops = 0;
    while (i < 6 && cyc < 12) begin
      bus.acc_valid = 1; bus.acc_in = s[i];
      acc_ok = (exp_q.size() < FIFO_DEPTH);
      checks++; if (bus.acc_ready !== acc_ok) begin errors++; $display("FAIL bp_ready cyc%0d got %b exp %b", cyc, bus.acc_ready, acc_ok); end
      tick();
      if (acc_ok) i++;
      cyc++;
    end
    checks++; if (i != 4 || bus.out_count !== 5'd4 || bus.acc_ready !== 1'b0) begin errors++; $display("FAIL bp_full got acc=%0d n=%0d rdy=%b exp 4 4 0", i, bus.out_count, bus.acc_ready); end
    bus.out_ready = 1; cyc = 0;
    while ((i < 6 || exp_q.size() != 0) && cyc < 40) begin
      bus.acc_valid = (i < 6);
      if (i < 6) bus.acc_in = s[i];
      acc_ok = bus.acc_valid && (exp_q.size() < FIFO_DEPTH);
      checks++; if (bus.out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL bp_valid got %b exp %b", bus.out_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        checks++; if (bus.out_data !== exp_q[0]) begin errors++; $display("FAIL bp_order got %h exp %h", bus.out_data, exp_q[0]); end
      end
      if (bus.out_valid === 1'b1) pops++;
      tick();
      if (acc_ok) i++;
      cyc++;
    end
    bus.acc_valid = 0; bus.out_ready = 0;
    checks++; if (i != 6 || exp_q.size() != 0) begin errors++; $display("FAIL bp_timeout got sent=%0d left=%0d exp 6 0", i, exp_q.size()); end
    checks++; if (pops != 6) begin errors++; $display("FAIL bp_pop_count got %0d exp 6", pops); end
  endtask

  task automatic test_push_pop();
    bus.pool_en = 0; bus.out_ready = 0;
    send(56'({$urandom(), $urandom()}));
    send(56'({$urandom(), $urandom()}));
    checks++; if (bus.out_count !== 5'd2) begin errors++; $display("FAIL pp_fill got %0d exp 2", bus.out_count); end
    bus.acc_valid = 1; bus.out_ready = 1;
    for (int k = 0; k < 10; k++) begin
      bus.acc_in = 56'({$urandom(), $urandom()});
      tick();
      checks++; if (bus.out_count !== 5'd2) begin errors++; $display("FAIL pp_count cyc%0d got %0d exp 2", k, bus.out_count); end
      checks++; if (bus.out_data !== exp_q[0]) begin errors++; $display("FAIL pp_order cyc%0d got %h exp %h", k, bus.out_data, exp_q[0]); end
    end
    bus.acc_valid = 0;
    drain();
  endtask

  task automatic test_random();
    logic [7:0] exp_d;
    for (int k = 0; k < 400; k++) begin
      bus.acc_valid = ($urandom_range(0, 3) != 0);
      bus.acc_in    = 56'({$urandom(), $urandom()});
      bus.flush     = ($urandom_range(0, 9) == 0);
      bus.thr_load  = ($urandom_range(0, 7) == 0);
      bus.thr_in    = 7'($urandom());
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 19) == 0) bus.pool_en = ~bus.pool_en;
      exp_d = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
      checks++; if (bus.acc_ready !== (exp_q.size() < FIFO_DEPTH)) begin errors++; $display("FAIL rnd_ready cyc%0d got %b", k, bus.acc_ready); end
      checks++; if (bus.out_count !== 5'(exp_q.size())) begin errors++; $display("FAIL rnd_count cyc%0d got %0d exp %0d", k, bus.out_count, exp_q.size()); end
      checks++; if (bus.out_data !== exp_d) begin errors++; $display("FAIL rnd_data cyc%0d got %h exp %h", k, bus.out_data, exp_d); end
      tick();
    end
    idle();
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) load_thr(7'd5);
    bus.pool_en = 0; bus.out_ready = 0;
    for (int i = 0; i < 3; i++) send(56'({$urandom(), $urandom()}));
    bus.pool_en = 1;
    send({8{7'd9}}); send({8{7'd9}});
    checks++; if (bus.out_count !== 5'd3) begin errors++; $display("FAIL rm_setup got %0d exp 3", bus.out_count); end
    rst = 1; tick(); rst = 0;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_count !== 5'd0 || bus.out_data !== 8'h00) begin errors++; $display("FAIL rm_fifo got v=%b n=%0d d=%h exp 0 0 00", bus.out_valid, bus.out_count, bus.out_data); end
    checks++; if (bus.acc_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b exp 1", bus.acc_ready); end
    // Zeroed thresholds make ch0=0 fire and ch1..7=-1 stay low.
    for (int i = 0; i < 4; i++) begin
      send(acc_for(8'h01));
      if (i < 3) begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_window%0d got %b exp 0", i, bus.out_valid); end
      end else begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h01) begin errors++; $display("FAIL rm_fresh got v=%b d=%h exp v=1 d=01", bus.out_valid, bus.out_data); end
      end
    end
    drain();
  endtask

  initial begin
    idle();
    rst = 1;
    test_reset();
    test_thresholds();
    test_signed();
    test_pooling();
    test_thr_coincide();
    test_backpressure();
    test_push_pop();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
